// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
// Operands are reduced to magnitudes at accept time. One quotient bit is produced
// per clock in CALC. FIX applies the result signs. Divide-by-zero and signed
// overflow skip the iteration and finish through SPEC one edge after accept.
module div_unit #(
   parameter int n = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [4:0]   AluOp,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] DivOut
);

   localparam logic [4:0] OP_DIV  = 5'b10001;
   localparam logic [4:0] OP_DIVU = 5'b10101;
   localparam logic [4:0] OP_REM  = 5'b11001;
   localparam logic [4:0] OP_REMU = 5'b11101;
   localparam int CW = $clog2(n + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, SPEC} state_t;

   state_t         state_reg;
   state_t         state_next;

   logic [n:0]     rem_reg;      // partial remainder, one guard bit wide
   logic [n-1:0]   quo_reg;      // dividend shifting out / quotient shifting in
   logic [n-1:0]   dvsr_reg;     // divisor magnitude
   logic [CW-1:0]  count_reg;    // iterations still to run
   logic           rem_op_reg;   // result is the remainder
   logic           neg_q_reg;    // quotient must be negated
   logic           neg_r_reg;    // remainder must be negated
   logic           done_reg;
   logic [n-1:0]   out_reg;

   // Operation decode and operand conditioning at the accept edge.
   logic           is_div_op;
   logic           op_signed;
   logic           op_rem;
   logic           a_neg;
   logic           b_neg;
   logic [n-1:0]   a_mag;
   logic [n-1:0]   b_mag;
   logic           b_zero;
   logic           ovf;
   logic           special;
   logic [n-1:0]   spec_val;
   logic           accept;

   // FSM output controls.
   logic           iterate;
   logic           load_out;

   // One restoring step.
   logic [n+1:0]   shifted;
   logic [n+1:0]   trial;
   logic           trial_ok;

   // Sign fix-up of the finished magnitudes.
   logic [n-1:0]   q_fixed;
   logic [n-1:0]   r_fixed;
   logic [n-1:0]   fix_val;

   // Decode the incoming request; the most negative value's magnitude fits in n unsigned bits.
   always_comb begin
      is_div_op = (AluOp == OP_DIV) || (AluOp == OP_DIVU) ||
                  (AluOp == OP_REM) || (AluOp == OP_REMU);
      op_signed = ~AluOp[2];
      op_rem    = AluOp[3];
      a_neg     = op_signed & A[n-1];
      b_neg     = op_signed & B[n-1];
      a_mag     = a_neg ? (~A + 1'b1) : A;
      b_mag     = b_neg ? (~B + 1'b1) : B;
      b_zero    = (B == '0);
      ovf       = op_signed && (A == {1'b1, {(n-1){1'b0}}}) && (B == {n{1'b1}});
      special   = b_zero | ovf;
      if (b_zero)
         spec_val = op_rem ? A : {n{1'b1}};
      else
         spec_val = op_rem ? '0 : A;
      accept    = (state_reg == IDLE) && start && is_div_op;
   end

   // Trial subtraction of the divisor from the shifted remainder; borrow means restore.
   always_comb begin
      shifted  = {rem_reg, quo_reg[n-1]};
      trial    = shifted - {2'b00, dvsr_reg};
      trial_ok = ~trial[n+1];
   end

   // Apply result signs: quotient negative on sign mismatch, remainder follows the dividend.
   always_comb begin
      q_fixed = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
      r_fixed = neg_r_reg ? (~rem_reg[n-1:0] + 1'b1) : rem_reg[n-1:0];
      fix_val = rem_op_reg ? r_fixed : q_fixed;
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = special ? SPEC : CALC;
         CALC: if (count_reg == CW'(1)) state_next = FIX;
         FIX:  state_next = IDLE;
         SPEC: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: busy is every non-IDLE cycle; FIX and SPEC publish a result.
   always_comb begin
      busy     = 1'b0;
      iterate  = 1'b0;
      load_out = 1'b0;
      case (state_reg)
         CALC: begin
            busy    = 1'b1;
            iterate = 1'b1;
         end
         FIX, SPEC: begin
            busy     = 1'b1;
            load_out = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: capture operands on accept, iterate in CALC, register the result and done pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         rem_reg    <= '0;
         quo_reg    <= '0;
         dvsr_reg   <= '0;
         count_reg  <= '0;
         rem_op_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         done_reg   <= 1'b0;
         out_reg    <= '0;
      end else begin
         done_reg <= load_out;
         if (accept) begin
            rem_reg    <= '0;
            // A special case parks its final answer here for SPEC to publish.
            quo_reg    <= special ? spec_val : a_mag;
            dvsr_reg   <= b_mag;
            count_reg  <= CW'(n);
            rem_op_reg <= op_rem;
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
         end else if (iterate) begin
            rem_reg   <= trial_ok ? trial[n:0] : shifted[n:0];
            quo_reg   <= {quo_reg[n-2:0], trial_ok};
            count_reg <= count_reg - CW'(1);
         end
         if (load_out)
            out_reg <= (state_reg == SPEC) ? quo_reg : fix_val;
      end
   end

   assign done   = done_reg;
   assign DivOut = out_reg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an arithmetic reference.
module tb_div_unit;

   localparam logic [4:0] DIV  = 5'b10001;
   localparam logic [4:0] DIVU = 5'b10101;
   localparam logic [4:0] REM  = 5'b11001;
   localparam logic [4:0] REMU = 5'b11101;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  AluOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] DivOut;

   int total = 0;
   int bad   = 0;

   div_unit #(.n(32)) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .AluOp  (AluOp),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .done   (done),
      .DivOut (DivOut)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: RISC-V M-extension semantics with plain integer arithmetic.
   function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      bit sgn;
      bit isrem;
      int sa;
      int sb;
      sgn   = (op == DIV) || (op == REM);
      isrem = (op == REM) || (op == REMU);
      if (b == 32'd0) return isrem ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return isrem ? 32'd0 : a;
      if (sgn) begin
         sa = a;
         sb = b;
         return isrem ? 32'(sa % sb) : 32'(sa / sb);
      end
      return isrem ? (a % b) : (a / b);
   endfunction

   function automatic bit ref_special(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      bit sgn;
      sgn = (op == DIV) || (op == REM);
      return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Issue one op (caller is at a negedge), count edges to done, check busy and result.
   // Returns at the negedge of the done cycle so a chained start can follow immediately.
   task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit inject, input string tag);
      int edges;
      int busy_cnt;
      bit seen;
      logic [31:0] exp;
      bit spc;
      start = 1'b1;
      AluOp = op;
      A     = a;
      B     = b;
      @(posedge clock);
      edges    = 1;
      busy_cnt = 0;
      seen     = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         start = 1'b0;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         if (inject && busy_cnt == 3) begin
            start = 1'b1;
            AluOp = DIVU;
            A     = $urandom;
            B     = $urandom | 32'd1;
         end
         @(posedge clock);
         edges++;
      end
      exp = ref_div(op, a, b);
      spc = ref_special(op, a, b);
      $display("op=%b A=%h B=%h -> DivOut=%h expect=%h edges=%0d busy_cycles=%0d",
               op, a, b, DivOut, exp, edges, busy_cnt);
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(edges), spc ? 32'd2 : 32'd34);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), spc ? 32'd1 : 32'd33);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_result"}, DivOut, exp);
   endtask

   // One quiet cycle after a result: done must have dropped and the unit stays idle.
   task automatic idle_check(input string tag);
      @(negedge clock);
      check({tag, "_done_dropped"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int done_hits;
      logic [4:0]  ops [4];
      logic [4:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      ops[0] = DIV; ops[1] = DIVU; ops[2] = REM; ops[3] = REMU;

      reset = 1'b1;
      start = 1'b0;
      AluOp = 5'd0;
      A     = 32'd0;
      B     = 32'd0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_divout", DivOut, 32'd0);

      // A non-divide op code must be ignored.
      start = 1'b1; AluOp = 5'b00000; A = 32'd10; B = 32'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         start = 1'b0;
         check("add_ignored_busy", 32'(busy), 32'd0);
         check("add_ignored_done", 32'(done), 32'd0);
      end

      run(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
      check("div_m7_2_const", DivOut, 32'hFFFF_FFFD);
      idle_check("div_m7_2");
      run(REM, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem_m7_2");
      check("rem_m7_2_const", DivOut, 32'hFFFF_FFFF);
      idle_check("rem_m7_2");
      run(DIVU, 32'hFFFF_FFFF, 32'h10, 1'b1, "divu_inject");
      check("divu_inject_const", DivOut, 32'h0FFF_FFFF);
      idle_check("divu_inject");
      run(REMU, 32'hFFFF_FFFF, 32'h10, 1'b0, "remu_f");
      check("remu_f_const", DivOut, 32'h0000_000F);
      idle_check("remu_f");
      run(DIV, 32'd1234, 32'd0, 1'b0, "div_by0");
      check("div_by0_const", DivOut, 32'hFFFF_FFFF);
      idle_check("div_by0");
      run(REMU, 32'd1234, 32'd0, 1'b0, "remu_by0");
      check("remu_by0_const", DivOut, 32'd1234);
      idle_check("remu_by0");
      run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
      check("div_ovf_const", DivOut, 32'h8000_0000);
      idle_check("div_ovf");
      run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
      check("rem_ovf_const", DivOut, 32'd0);
      idle_check("rem_ovf");

      // Reset ten cycles into an operation abandons it.
      start = 1'b1; AluOp = DIVU; A = 32'd5000; B = 32'd3;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_done", 32'(done), 32'd0);
      check("midreset_divout", DivOut, 32'd0);
      reset = 1'b0;
      done_hits = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done) done_hits++;
      end
      check("midreset_no_done", 32'(done_hits), 32'd0);
      check("midreset_idle", 32'(busy), 32'd0);

      // Back-to-back: second start issued in the done cycle of the first.
      run(DIVU, 32'd100, 32'd7, 1'b0, "divu_100_7");
      check("divu_100_7_const", DivOut, 32'd14);
      run(REMU, 32'd100, 32'd7, 1'b0, "remu_100_7");
      check("remu_100_7_const", DivOut, 32'd2);
      idle_check("remu_100_7");

      // Randomized operations with occasional special-case operands.
      for (int k = 0; k < 24; k++) begin
         rop = ops[$urandom_range(0, 3)];
         ra  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = $urandom_range(1, 15);
            2: begin
               ra = 32'h8000_0000;
               rb = 32'hFFFF_FFFF;
            end
            3: rb = $urandom >> $urandom_range(1, 31);
            default: rb = $urandom;
         endcase
         run(rop, ra, rb, k[2], "rand");
         if (k[0]) idle_check("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider implementing the RV32M division ops (DIV, DIVU, REM, REMU) that the combinational ALU does not cover.
- Sits beside the ALU in the execute stage and consumes the same AluOp and A/B operand buses.
- Accepts one operation per start pulse, holds busy so the pipeline can stall, and returns the result with a one-cycle done pulse.

Parameters:
- n, 32, operand/result width in bits; n >= 4.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to begin an operation; sampled only in IDLE
- AluOp  input  5  operation code, sampled with start: 5'b10001 DIV, 5'b10101 DIVU, 5'b11001 REM, 5'b11101 REMU
- A  input  n  dividend, sampled with start
- B  input  n  divisor, sampled with start
- busy  output  1  high while an accepted operation is in progress
- done  output  1  one-cycle pulse; DivOut is valid in this cycle
- DivOut  output  n  quotient or remainder, per AluOp

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, DivOut=0, state=IDLE. All internal registers are cleared.
- Reset mid-operation: the operation is abandoned, no done pulse is produced, and the unit is in IDLE next cycle.
- States: IDLE, CALC, FIX, SPEC.
- IDLE, start=1 and AluOp is one of the four div codes (accept edge E0):
  - Latch the op, sign flags, |A| and |B| (unsigned ops take the raw values).
  - Clear the partial remainder and set counter=n.
  - busy=1 from the next cycle.
  - Next state is CALC, or SPEC if a special case is detected at E0.
- IDLE, start=1 with any other AluOp: ignored, no state change.
- start while busy: ignored; the operation in flight is unaffected.
- CALC: one iteration per edge.
  - Shift {rem, quo} left 1 bit; trial = rem - divisor.
  - If trial is non-negative, rem = trial and quo LSB = 1; otherwise restore.
  - Counter decrements each iteration; after the n-th iteration (edge En) go to FIX.
- FIX (edge En+1):
  - Signed ops: negate the quotient if sign(A) != sign(B); the remainder takes the sign of A.
  - Write DivOut (quotient for DIV/DIVU, remainder for REM/REMU).
  - done=1 and busy=0 for the following cycle; go to IDLE.
- Latency for normal ops: done is high in the cycle after edge E(n+1), i.e. n+2 edges counted from the accept edge inclusive (34 for n=32).
- Special cases are detected at E0, bypass CALC, and complete via SPEC at E1 (done in the cycle after E1):
  - B=0: DIV/DIVU -> all ones; REM/REMU -> A.
  - Signed overflow (DIV/REM with A=most negative, B=-1): DIV -> A (0x80000000); REM -> 0.
- DivOut holds its last value until the next FIX/SPEC write. done is never high for two consecutive cycles.
- A new start is accepted in the same cycle done is high, since the state is IDLE then.
- Width rules:
  - All arithmetic is unsigned n-bit on magnitudes; the internal remainder register is n+1 bits.
  - Magnitude of the most negative value = 2^(n-1), representable as unsigned n-bit.
  - Results are truncated to n bits.

Test Plan:
- Reset held 2 cycles, then released -> busy=0, done=0, DivOut=0; start with AluOp=5'b00000 (ADD) -> no busy, no done.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy for 33 cycles; done exactly 34 edges after accept; DivOut=0xFFFFFFFD (-3). Repeat as REM -> 0xFFFFFFFF (-1).
- DIVU A=0xFFFFFFFF, B=0x10 -> 0x0FFFFFFF; REMU same operands -> 0x0000000F. Assert start during busy with different operands -> result unchanged.
- Divide by zero: DIV A=1234, B=0 -> DivOut=0xFFFFFFFF, done after E1; REMU A=1234, B=0 -> 1234.
- Overflow: DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM same -> 0; both complete via SPEC.
- Assert reset 10 cycles into a DIVU -> no done pulse, busy=0 next cycle; a following DIVU 100/7 -> 14, and back-to-back start in the done cycle with REMU 100/7 -> 2.
